// File: rtl/true_dpbram_ex_pkg.sv
// Shared definitions for the two-port block RAM: clear-FSM states,
// read-during-write mode constants and a byte-count helper.
package true_dpbram_ex_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    // Cross-port read of a word being written in the same cycle
    localparam int RDW_READ_FIRST  = 0;  // reader sees the old word
    localparam int RDW_WRITE_FIRST = 1;  // reader sees the merged new word

    // Number of byte lanes in a data word
    function automatic int nbyte(input int dwidth);
        return dwidth / 8;
    endfunction

endpackage

// File: rtl/true_dpbram_ex_rd_pipe.sv
// Read-result pipeline for one RAM port: RD_LAT stages of data plus a
// valid bit. Each stage only loads when the stage before it is valid, so the
// output word holds its last read result while no read is in flight.
module true_dpbram_ex_rd_pipe #(
    parameter int DWIDTH = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [DWIDTH-1:0] rd_data,
    output logic [DWIDTH-1:0] q,
    output logic              q_valid
);

    logic [RD_LAT-1:0] vld_q;
    logic [DWIDTH-1:0] dat_q [RD_LAT];

    // Shift valid bits every cycle; move data only along with a valid bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments let every stage sample the old value of the stage before it, which is what makes this a shift register.
            vld_q[0] <= rd_en;
            if (rd_en) begin
                dat_q[0] <= rd_data;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign q       = dat_q[RD_LAT-1];
    assign q_valid = vld_q[RD_LAT-1];

endmodule

// File: rtl/true_dpbram_ex.sv
// Two-port block RAM for pooling/PE line buffers: byte-enable writes,
// 1- or 2-cycle registered reads with valid strobes, port-0-wins write
// collisions with a collision pulse, selectable read-during-write behaviour
// across ports, and a clear FSM that zero-fills the array one word per cycle.
module true_dpbram_ex
    import true_dpbram_ex_pkg::*;
#(
    parameter int DWIDTH     = 16,
    parameter int AWIDTH     = 12,
    parameter int MEM_SIZE   = 3840,
    parameter int RD_LAT     = 1,
    parameter int RDW_MODE   = RDW_READ_FIRST,
    parameter int CLR_ON_RST = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    output logic                  busy_o,
    input  logic [AWIDTH-1:0]     addr0_i,
    input  logic                  ce0_i,
    input  logic                  we0_i,
    input  logic [DWIDTH/8-1:0]   be0_i,
    input  logic [DWIDTH-1:0]     d0_i,
    input  logic [AWIDTH-1:0]     addr1_i,
    input  logic                  ce1_i,
    input  logic                  we1_i,
    input  logic [DWIDTH/8-1:0]   be1_i,
    input  logic [DWIDTH-1:0]     d1_i,
    output logic [DWIDTH-1:0]     q0_o,
    output logic                  q0_valid_o,
    output logic [DWIDTH-1:0]     q1_o,
    output logic                  q1_valid_o,
    output logic                  coll_o
);

    localparam int                NB        = nbyte(DWIDTH);
    localparam logic [AWIDTH:0]   SIZE_W    = (AWIDTH+1)'(MEM_SIZE);
    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(MEM_SIZE - 1);
    // With auto-clear the FSM already sits in CLEAR while reset is held,
    // so busy_o is high during reset and clearing starts on the first edge.
    localparam clr_state_t        RST_STATE = (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;

    logic [DWIDTH-1:0] mem [MEM_SIZE];

    clr_state_t        state_q, state_d;
    logic [AWIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic              busy;

    logic              in0, in1;
    logic              wr0, wr1;
    logic              rd0, rd1;
    logic [DWIDTH-1:0] rdata0, rdata1;
    logic              coll_q;

    // Overlay the enabled byte lanes of new_w onto old_w
    function automatic logic [DWIDTH-1:0] merge_bytes(
        input logic [DWIDTH-1:0] old_w,
        input logic [DWIDTH-1:0] new_w,
        input logic [NB-1:0]     be
    );
        logic [DWIDTH-1:0] r;
        r = old_w;
        for (int k = 0; k < NB; k++) begin
            if (be[k]) begin
                r[8*k +: 8] = new_w[8*k +: 8];
            end
        end
        return r;
    endfunction

    assign busy   = (state_q == ST_CLEAR);
    assign busy_o = busy;

    // Clear FSM state and word counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RST_STATE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Clear FSM next state: walk 0..MEM_SIZE-1, leave CLEAR on the last word
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (clr_i) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + AWIDTH'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Port qualification, collision arbitration and read-data selection
    always_comb begin
        in0 = ({1'b0, addr0_i} < SIZE_W);
        in1 = ({1'b0, addr1_i} < SIZE_W);
        rd0 = ce0_i & ~we0_i & ~busy;
        rd1 = ce1_i & ~we1_i & ~busy;
        wr0 = ce0_i & we0_i & ~busy & in0;
        // Port 0 wins a same-address write outright: port 1 is dropped entirely
        wr1 = ce1_i & we1_i & ~busy & in1 & ~(wr0 & (addr0_i == addr1_i));

        rdata0 = '0;
        if (in0) begin
            rdata0 = mem[addr0_i];
        end
        if (RDW_MODE == RDW_WRITE_FIRST && wr1 && addr1_i == addr0_i) begin
            rdata0 = merge_bytes(rdata0, d1_i, be1_i);
        end

        rdata1 = '0;
        if (in1) begin
            rdata1 = mem[addr1_i];
        end
        if (RDW_MODE == RDW_WRITE_FIRST && wr0 && addr0_i == addr1_i) begin
            rdata1 = merge_bytes(rdata1, d0_i, be0_i);
        end
    end

    // RAM array writes: clear sweep or byte-enabled port writes
    // NOTE: the array has no reset so it can map onto block RAM; zero-filling is the clear FSM's job.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[clr_cnt_q] <= '0;
        end else begin
            if (wr1) begin
                for (int k = 0; k < NB; k++) begin
                    if (be1_i[k]) begin
                        mem[addr1_i][8*k +: 8] <= d1_i[8*k +: 8];
                    end
                end
            end
            if (wr0) begin
                for (int k = 0; k < NB; k++) begin
                    if (be0_i[k]) begin
                        mem[addr0_i][8*k +: 8] <= d0_i[8*k +: 8];
                    end
                end
            end
        end
    end

    // Write/write collision flag, reported one cycle after the collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_q <= 1'b0;
        end else begin
            coll_q <= ce0_i & we0_i & ce1_i & we1_i & ~busy & (addr0_i == addr1_i);
        end
    end

    assign coll_o = coll_q;

    true_dpbram_ex_rd_pipe #(
        .DWIDTH (DWIDTH),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en   (rd0),
        .rd_data (rdata0),
        .q       (q0_o),
        .q_valid (q0_valid_o)
    );

    true_dpbram_ex_rd_pipe #(
        .DWIDTH (DWIDTH),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en   (rd1),
        .rd_data (rdata1),
        .q       (q1_o),
        .q_valid (q1_valid_o)
    );

endmodule
